// File: rtl/core_bus_arbiter_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
package core_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

    localparam logic REQ_INSTR = 1'b0;
    localparam logic REQ_DATA  = 1'b1;

    localparam int STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/naive_bus.sv
// Simple req/gnt memory bus: request accepted on req&gnt, rd_data one cycle later.
interface naive_bus;

    logic        rd_req;
    logic        rd_gnt;
    logic [31:0] rd_addr;
    logic [31:0] rd_data;
    logic        wr_req;
    logic        wr_gnt;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
        input  rd_gnt, wr_gnt, rd_data
    );

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
        output rd_gnt, wr_gnt, rd_data
    );

endinterface

// File: rtl/core_bus_arbiter_starve_cnt.sv
// Saturating up-counter with clear; clear wins over increment.
module core_arb_starve_cnt #(
    parameter int LIMIT = 4,
    parameter int W     = $clog2(LIMIT + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && cnt != W'(LIMIT))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/core_bus_arbiter.sv
// Arbitrates instruction (s0) and data (s1) requesters onto one memory port,
// data-first with starvation override, locking on an ungranted request.
module core_bus_arbiter
    import core_bus_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input logic       clk,
    input logic       rst_n,
    naive_bus.slave   s0,
    naive_bus.slave   s1,
    naive_bus.master  m
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    arb_state_t    state_q, state_d;
    logic [CW-1:0] starve_cnt;
    logic          req0, req1, starved;
    logic          sel_vld, sel;
    logic          fwd_rd, fwd_wr, rd_acc, wr_acc, acc, acc0;
    logic          rsp_vld_q, rsp_sel_q;

    assign req0    = s0.rd_req | s0.wr_req;
    assign req1    = s1.rd_req | s1.wr_req;
    assign starved = (starve_cnt == CW'(STARVE_LIMIT));

    // Selection; reset forces no owner so everything downstream goes quiet at once.
    always_comb begin
        sel_vld = 1'b0;
        sel     = REQ_DATA;
        case (state_q)
            LOCK0: begin sel_vld = req0; sel = REQ_INSTR; end
            LOCK1: begin sel_vld = req1; sel = REQ_DATA;  end
            default: begin
                if (req0 && req1) begin
                    sel_vld = 1'b1;
                    sel     = starved ? REQ_INSTR : REQ_DATA;
                end else if (req0) begin
                    sel_vld = 1'b1;
                    sel     = REQ_INSTR;
                end else if (req1) begin
                    sel_vld = 1'b1;
                    sel     = REQ_DATA;
                end
            end
        endcase
        if (!rst_n)
            sel_vld = 1'b0;
    end

    // Forwarding; a read takes priority over a simultaneous write from the same requester.
    always_comb begin
        fwd_rd     = 1'b0;
        fwd_wr     = 1'b0;
        m.rd_addr  = '0;
        m.wr_addr  = '0;
        m.wr_data  = '0;
        m.wr_be    = '0;
        if (sel_vld) begin
            if (sel == REQ_DATA) begin
                fwd_rd    = s1.rd_req;
                fwd_wr    = s1.wr_req & ~s1.rd_req;
                m.rd_addr = s1.rd_addr;
                m.wr_addr = s1.wr_addr;
                m.wr_data = s1.wr_data;
                m.wr_be   = s1.wr_be;
            end else begin
                fwd_rd    = s0.rd_req;
                fwd_wr    = s0.wr_req & ~s0.rd_req;
                m.rd_addr = s0.rd_addr;
                m.wr_addr = s0.wr_addr;
                m.wr_data = s0.wr_data;
                m.wr_be   = s0.wr_be;
            end
        end
    end

    assign m.rd_req  = fwd_rd;
    assign m.wr_req  = fwd_wr;
    assign rd_acc    = fwd_rd & m.rd_gnt;
    assign wr_acc    = fwd_wr & m.wr_gnt;
    assign acc       = rd_acc | wr_acc;
    assign acc0      = acc & (sel == REQ_INSTR);

    assign s0.rd_gnt = rd_acc & (sel == REQ_INSTR);
    assign s0.wr_gnt = wr_acc & (sel == REQ_INSTR);
    assign s1.rd_gnt = rd_acc & (sel == REQ_DATA);
    assign s1.wr_gnt = wr_acc & (sel == REQ_DATA);

    // Hold the owner while its request waits so a pending address is never swapped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sel_vld && !acc) state_d = (sel == REQ_DATA) ? LOCK1 : LOCK0;
            LOCK0:   if (!req0 || acc) state_d = IDLE;
            LOCK1:   if (!req1 || acc) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    core_arb_starve_cnt #(.LIMIT(STARVE_LIMIT), .W(CW)) u_starve (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (~req0 | acc0),
        .inc   (req0 & ~acc0),
        .cnt   (starve_cnt)
    );

    // Response tag steers next-cycle read data back to whoever owned the read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_vld_q <= 1'b0;
            rsp_sel_q <= REQ_INSTR;
        end else begin
            rsp_vld_q <= rd_acc;
            if (rd_acc)
                rsp_sel_q <= sel;
        end
    end

    assign s0.rd_data = (rsp_vld_q && rsp_sel_q == REQ_INSTR) ? m.rd_data : '0;
    assign s1.rd_data = (rsp_vld_q && rsp_sel_q == REQ_DATA)  ? m.rd_data : '0;

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Scoreboard bench: driver predicts every cycle's outputs from arbitration rules,
// monitor compares on the falling edge.
module tb_core_bus_arbiter;

    localparam int LIMIT = 4;

    typedef struct packed {
        logic [1:0]       rd;
        logic [1:0]       wr;
        logic [1:0][31:0] ra;
        logic [1:0][31:0] wa;
        logic [1:0][31:0] wd;
        logic [1:0][3:0]  be;
        logic             mrg;
        logic             mwg;
        logic [31:0]      mrd;
    } stim_t;

    // {s0 rd_gnt, s0 wr_gnt, s1 rd_gnt, s1 wr_gnt, m rd_req, m wr_req,
    //  m rd_addr, m wr_addr, m wr_data, m wr_be, s0 rd_data, s1 rd_data}
    typedef logic [169:0] obs_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    naive_bus b0();
    naive_bus b1();
    naive_bus bm();

    core_bus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s0    (b0),
        .s1    (b1),
        .m     (bm)
    );

    obs_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    // reference model state
    logic lk_v = 1'b0, lk_i = 1'b0;
    logic tag_v = 1'b0, tag_i = 1'b0;
    int   stv = 0;

    function automatic stim_t rnd_stim();
        stim_t s;
        s.rd  = 2'($urandom_range(0, 3));
        s.wr  = 2'($urandom_range(0, 3));
        for (int i = 0; i < 2; i++) begin
            s.ra[i] = $urandom;
            s.wa[i] = $urandom;
            s.wd[i] = $urandom;
            s.be[i] = 4'($urandom_range(0, 15));
        end
        s.mrg = ($urandom_range(0, 9) < 7);
        s.mwg = ($urandom_range(0, 9) < 7);
        s.mrd = $urandom;
        return s;
    endfunction

    function automatic stim_t idle_stim();
        stim_t s;
        s    = rnd_stim();
        s.rd = 2'b00;
        s.wr = 2'b00;
        return s;
    endfunction

    task automatic apply(input stim_t st);
        b0.rd_req = st.rd[0]; b0.wr_req = st.wr[0]; b0.rd_addr = st.ra[0];
        b0.wr_addr = st.wa[0]; b0.wr_data = st.wd[0]; b0.wr_be = st.be[0];
        b1.rd_req = st.rd[1]; b1.wr_req = st.wr[1]; b1.rd_addr = st.ra[1];
        b1.wr_addr = st.wa[1]; b1.wr_data = st.wd[1]; b1.wr_be = st.be[1];
        bm.rd_gnt = st.mrg; bm.wr_gnt = st.mwg; bm.rd_data = st.mrd;
    endtask

    function automatic obs_t sample();
        return {b0.rd_gnt, b0.wr_gnt, b1.rd_gnt, b1.wr_gnt, bm.rd_req, bm.wr_req,
                bm.rd_addr, bm.wr_addr, bm.wr_data, bm.wr_be, b0.rd_data, b1.rd_data};
    endfunction

    // Apply one cycle of stimulus, predict the visible outputs, advance the model.
    task automatic drive(input stim_t st);
        logic [1:0]  rq, rg, wg;
        logic        w_v, w_i, fr, fw, acc;
        logic [31:0] ra, wa, wd, d0, d1;
        logic [3:0]  be;
        apply(st);
        rq = st.rd | st.wr;
        w_v = 1'b0; w_i = 1'b0;
        if (lk_v) begin
            w_v = rq[lk_i]; w_i = lk_i;
        end else if (rq == 2'b11) begin
            w_v = 1'b1; w_i = (stv == LIMIT) ? 1'b0 : 1'b1;
        end else if (rq != 2'b00) begin
            w_v = 1'b1; w_i = rq[1];
        end
        fr = 1'b0; fw = 1'b0; rg = 2'b00; wg = 2'b00;
        ra = '0; wa = '0; wd = '0; be = '0;
        if (w_v) begin
            fr = st.rd[w_i];
            fw = st.wr[w_i] & ~st.rd[w_i];
            ra = st.ra[w_i]; wa = st.wa[w_i]; wd = st.wd[w_i]; be = st.be[w_i];
            rg[w_i] = fr & st.mrg;
            wg[w_i] = fw & st.mwg;
        end
        d0 = (tag_v && !tag_i) ? st.mrd : 32'h0;
        d1 = (tag_v &&  tag_i) ? st.mrd : 32'h0;
        exp_q.push_back({rg[0], wg[0], rg[1], wg[1], fr, fw, ra, wa, wd, be, d0, d1});
        acc = w_v && (rg[w_i] || wg[w_i]);
        if (lk_v) begin
            if (acc || !rq[lk_i]) lk_v = 1'b0;
        end else if (w_v && !acc) begin
            lk_v = 1'b1; lk_i = w_i;
        end
        if (!rq[0] || (w_v && !w_i && acc)) stv = 0;
        else if (stv < LIMIT)               stv = stv + 1;
        tag_v = w_v && rg[w_i];
        tag_i = w_i;
    endtask

    task automatic step(input stim_t st);
        @(posedge clk); #1;
        drive(st);
    endtask

    // Outputs that must be quiet whenever reset is asserted.
    task automatic chk_quiet(input string nm);
        logic [69:0] q;
        q = {b0.rd_gnt, b0.wr_gnt, b1.rd_gnt, b1.wr_gnt, bm.rd_req, bm.wr_req,
             b0.rd_data, b1.rd_data};
        n_vec++;
        if (q !== '0) begin
            n_err++;
            $display("FAIL %s: outputs %h, required all zero", nm, q);
        end
    endtask

    task automatic model_reset();
        lk_v = 1'b0; tag_v = 1'b0; stv = 0;
    endtask

    // monitor
    initial begin
        obs_t e, o;
        forever begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                o = sample();
                n_vec++;
                if (o !== e) begin
                    n_err++;
                    $display("FAIL scoreboard cyc %0d: got %h want %h", cyc, o, e);
                end
            end
        end
    end

    initial begin
        stim_t st;
        rst_n = 1'b0;
        st = rnd_stim();
        st.rd = 2'b11; st.mrg = 1'b1; st.mwg = 1'b1;
        apply(st);
        #13 chk_quiet("reset_hold");
        @(posedge clk); #1;
        apply(idle_stim());
        #1 rst_n = 1'b1;

        // single instruction read, immediate grant, then data return
        st = idle_stim(); st.rd[0] = 1'b1; st.ra[0] = 32'h100; st.mrg = 1'b1;
        step(st);
        step(idle_stim());

        // both read every cycle with constant grant: starvation rotation
        for (int i = 0; i < 15; i++) begin
            st = rnd_stim(); st.rd = 2'b11; st.wr = 2'b00; st.mrg = 1'b1;
            step(st);
        end
        step(idle_stim());

        // data write stalled 3 cycles while instruction fetch waits
        st = rnd_stim();
        st.rd = 2'b01; st.wr = 2'b10; st.wa[1] = 32'h200; st.be[1] = 4'hF;
        st.mrg = 1'b1; st.mwg = 1'b0;
        for (int i = 0; i < 4; i++) begin
            st.mrd = $urandom;
            st.mwg = (i == 3);
            step(st);
        end
        st = idle_stim(); st.rd[0] = 1'b1; st.mrg = 1'b1;
        step(st);
        step(idle_stim());

        // back-to-back reads from different owners
        st = idle_stim(); st.rd[0] = 1'b1; st.mrg = 1'b1; step(st);
        st = idle_stim(); st.rd[1] = 1'b1; st.mrg = 1'b1; step(st);
        step(idle_stim());
        step(idle_stim());

        for (int i = 0; i < 400; i++)
            step(rnd_stim());

        // reset pulse in the cycle LOCK1's read is finally granted
        step(idle_stim());
        st = rnd_stim(); st.rd = 2'b11; st.wr = 2'b00; st.mrg = 1'b0;
        for (int i = 0; i < 5; i++) step(st);
        @(posedge clk); #1;
        st.mrg = 1'b1;
        apply(st);
        #2 rst_n = 1'b0;
        #1 chk_quiet("reset_async");
        model_reset();
        apply(idle_stim());
        @(posedge clk); #1;
        chk_quiet("reset_edge");
        #1 rst_n = 1'b1;
        step(idle_stim());
        st = rnd_stim(); st.rd = 2'b11; st.wr = 2'b00; st.mrg = 1'b1;
        step(st);
        step(idle_stim());

        for (int i = 0; i < 100; i++)
            step(rnd_stim());

        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
